// File: rtl/alu_result_reg.sv
// Result-capture stage behind the lab ALU: one capture per Capture press, B operand feedback,
// and an optional tagged history FIFO built only when ALU_HIST_EN is defined.
module alu_result_reg #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [7:0]    ALUout,
  input  logic [1:0]    Function,
  input  logic          Capture,
  input  logic          hist_rd,
  output logic [7:0]    Result,
  output logic [3:0]    B_fb,
  output logic [9:0]    hist_data,
  output logic [CW-1:0] hist_count,
  output logic          hist_empty,
  output logic          hist_full,
  output logic          hist_ovf
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_nxt;
  logic   cap;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Capture)  state_nxt = HOLD;
      HOLD:    if (!Capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A capture fires only on the first cycle of a press; HOLD absorbs the rest of it.
  always_comb begin
    cap = 1'b0;
    if (state == IDLE && Capture) cap = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Reset)    Result <= '0;
    else if (cap) Result <= ALUout;
  end

  assign B_fb = Result[3:0];

`ifdef ALU_HIST_EN
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          empty, full, push, pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign push  = cap;
  assign pop   = hist_rd && !empty;

  // When full, wr_ptr == rd_ptr, so a lone push overwrites the head and rd_ptr steps past it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)                 wr_ptr <= wr_ptr + AW'(1);
      if (pop || (push && full)) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop && full) ovf <= 1'b1;
      if (push && !pop && !full)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= {Function, ALUout};
  end

  assign hist_data  = empty ? '0 : mem[rd_ptr];
  assign hist_count = count;
  assign hist_empty = empty;
  assign hist_full  = full;
  assign hist_ovf   = ovf;
`else
  logic unused_hist;
  assign unused_hist = ^{hist_rd, Function};

  assign hist_data  = '0;
  assign hist_count = '0;
  assign hist_empty = 1'b1;
  assign hist_full  = 1'b0;
  assign hist_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_reg.sv
// Bench for alu_result_reg: table vectors, hand-written corner sequences and random stimulus
// against a queue-based reference model; works with or without ALU_HIST_EN.
module tb_alu_result_reg;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ALU_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset, Capture, hist_rd;
  logic [7:0]    ALUout;
  logic [1:0]    Function;
  logic [7:0]    Result;
  logic [3:0]    B_fb;
  logic [9:0]    hist_data;
  logic [CW-1:0] hist_count;
  logic          hist_empty, hist_full, hist_ovf;

  alu_result_reg #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .ALUout(ALUout), .Function(Function),
    .Capture(Capture), .hist_rd(hist_rd), .Result(Result), .B_fb(B_fb),
    .hist_data(hist_data), .hist_count(hist_count), .hist_empty(hist_empty),
    .hist_full(hist_full), .hist_ovf(hist_ovf)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a press is Capture high while it was low (or reset) on the previous edge.
  logic [9:0] q[$];
  bit         m_prev_cap;
  logic [7:0] m_result;
  bit         m_ovf;

  function automatic void model_edge();
    bit take;
    if (Reset) begin
      q.delete();
      m_prev_cap = 1'b0;
      m_result   = '0;
      m_ovf      = 1'b0;
      return;
    end
    take = Capture && !m_prev_cap;
    if (HIST) begin
      if (hist_rd && q.size() > 0) void'(q.pop_front());
      if (take) begin
        q.push_back({Function, ALUout});
        if (q.size() > DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
    if (take) m_result = ALUout;
    m_prev_cap = Capture;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".Result"},     32'(Result),     32'(m_result));
    chk({tag, ".B_fb"},       32'(B_fb),       32'(m_result[3:0]));
    chk({tag, ".hist_count"}, 32'(hist_count), 32'(q.size()));
    chk({tag, ".hist_empty"}, 32'(hist_empty), 32'(q.size() == 0));
    chk({tag, ".hist_full"},  32'(hist_full),  32'(q.size() == DEPTH));
    chk({tag, ".hist_ovf"},   32'(hist_ovf),   32'(m_ovf));
    chk({tag, ".hist_data"},  32'(hist_data),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic step(input string tag);
    @(posedge Clock);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic r, input logic c, input logic [7:0] a,
                       input logic [1:0] f, input logic rd);
    Reset = r; Capture = c; ALUout = a; Function = f; hist_rd = rd;
  endtask

  typedef struct {
    logic       cap;
    logic [7:0] alu;
    logic [1:0] fn;
    logic [7:0] exp_res;
    int         exp_cnt;
    logic [9:0] exp_hd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl = '{
      '{1'b1, 8'h3C, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h3C, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h3C, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h3C, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h3C, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h55, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b0, 8'h55, 2'b00, 8'h3C, 1, 10'h03C},
      '{1'b1, 8'h55, 2'b10, 8'h55, 2, 10'h03C},
      '{1'b0, 8'h55, 2'b10, 8'h55, 2, 10'h03C}
    };

    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    step("rst0");
    step("rst1");
    chk("reset.Result", 32'(Result), 0);
    chk("reset.B_fb", 32'(B_fb), 0);
    chk("reset.hist_count", 32'(hist_count), 0);
    chk("reset.hist_empty", 32'(hist_empty), 1);
    chk("reset.hist_full", 32'(hist_full), 0);
    chk("reset.hist_ovf", 32'(hist_ovf), 0);
    chk("reset.hist_data", 32'(hist_data), 0);

    for (int i = 0; i < 9; i++) begin
      drive(1'b0, tbl[i].cap, tbl[i].alu, tbl[i].fn, 1'b0);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.Result", i), 32'(Result), 32'(tbl[i].exp_res));
      chk($sformatf("tbl%0d.B_fb", i), 32'(B_fb), 32'(tbl[i].exp_res[3:0]));
      chk($sformatf("tbl%0d.count", i), 32'(hist_count), HIST ? tbl[i].exp_cnt : 0);
      chk($sformatf("tbl%0d.hist_data", i), 32'(hist_data), HIST ? 32'(tbl[i].exp_hd) : 0);
      chk($sformatf("tbl%0d.empty", i), 32'(hist_empty), HIST ? 0 : 1);
    end

    // Overflow: five captures into a four-entry FIFO drops the oldest.
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    step("ovf.rst");
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 8'(i), 2'b01, 1'b0);
      step("ovf.press");
      drive(1'b0, 1'b0, 8'(i), 2'b01, 1'b0);
      step("ovf.rel");
    end
    chk("ovf.full", 32'(hist_full), HIST ? 1 : 0);
    chk("ovf.ovf", 32'(hist_ovf), HIST ? 1 : 0);
    chk("ovf.count", 32'(hist_count), HIST ? 4 : 0);
    chk("ovf.Result", 32'(Result), 5);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("ovf.pop%0d", i), 32'(hist_data), HIST ? 32'({2'b01, 8'(i)}) : 0);
      drive(1'b0, 1'b0, 8'h00, 2'b01, 1'b1);
      step("ovf.pop");
    end
    drive(1'b0, 1'b0, 8'h00, 2'b01, 1'b0);
    chk("ovf.empty", 32'(hist_empty), 1);
    chk("ovf.ovf_sticky", 32'(hist_ovf), HIST ? 1 : 0);

    // Full FIFO: push and pop together keep the count and never flag overflow.
    drive(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    step("pp.rst");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'h11 + i), 2'b11, 1'b0);
      step("pp.press");
      drive(1'b0, 1'b0, 8'h00, 2'b11, 1'b0);
      step("pp.rel");
    end
    chk("pp.full", 32'(hist_full), HIST ? 1 : 0);
    drive(1'b0, 1'b1, 8'hAA, 2'b11, 1'b1);
    step("pp.both");
    chk("pp.count", 32'(hist_count), HIST ? 4 : 0);
    chk("pp.ovf", 32'(hist_ovf), 0);
    chk("pp.head", 32'(hist_data), HIST ? 32'h312 : 0);
    drive(1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) step("pp.drain");
    chk("pp.drained", 32'(hist_empty), 1);
    step("pp.rd_empty");
    chk("pp.rd_empty.count", 32'(hist_count), 0);
    chk("pp.rd_empty.data", 32'(hist_data), 0);
    chk("pp.rd_empty.ovf", 32'(hist_ovf), 0);
    chk("pp.Result", 32'(Result), 32'hAA);

    // Reset during HOLD with Capture still high, then an immediate new capture.
    drive(1'b0, 1'b1, 8'h77, 2'b10, 1'b0);
    step("mid.press");
    step("mid.hold");
    drive(1'b1, 1'b1, 8'h77, 2'b10, 1'b0);
    step("mid.rst");
    chk("mid.rst.Result", 32'(Result), 0);
    chk("mid.rst.count", 32'(hist_count), 0);
    chk("mid.rst.empty", 32'(hist_empty), 1);
    drive(1'b0, 1'b1, 8'h88, 2'b10, 1'b0);
    step("mid.after");
    chk("mid.after.Result", 32'(Result), 32'h88);
    chk("mid.after.B_fb", 32'(B_fb), 32'h8);
    chk("mid.after.count", 32'(hist_count), HIST ? 1 : 0);
    chk("mid.after.data", 32'(hist_data), HIST ? 32'h288 : 0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
            2'($urandom), $urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_reg.md
# alu_result_reg

Result-capture stage that sits directly downstream of the lab ALU. It registers the ALU's 8-bit output once per button press and feeds the low nibble back to the ALU's B operand, which closes the accumulate loop. It also keeps a small history FIFO of past results, tagged with the function that produced each one, for display and readback.

## Interface
Parameters:
- `DEPTH`, default 4: history FIFO entries. Must be a power of two, ≥ 2.
- `CW`, default $clog2(DEPTH)+1: count width. Derived; do not override.

Ports:
- `Clock` input 1: single clock; all state on rising edge.
- `Reset` input 1: synchronous, active-high.
- `ALUout` input 8: ALU result being consumed.
- `Function` input 2: ALU function select; stored as the history tag.
- `Capture` input 1: level request (debounced KEY). Held high for any number of cycles.
- `hist_rd` input 1: pop one history entry.
- `Result` output 8: registered captured result.
- `B_fb` output 4: `Result[3:0]`, the feedback operand to the ALU B input.
- `hist_data` output 10: `{tag[1:0], result[7:0]}` at the FIFO head; 0 when empty.
- `hist_count` output CW: occupied entries.
- `hist_empty` output 1; `hist_full` output 1.
- `hist_ovf` output 1: sticky; an entry was dropped.

## Operation
- Capture FSM states: IDLE, HOLD.
  - In IDLE with `Capture`=1: capture, then go to HOLD.
  - In HOLD with `Capture`=0: go to IDLE.
  - All other cases: stay in the current state.
- Exactly one capture per press, no matter how long `Capture` is held. A new press needs at least one cycle of `Capture`=0 first.
- On capture:
  - `Result` <= `ALUout`.
  - Push `{Function, ALUout}` into the FIFO.
- The FIFO is a circular buffer with wrapping rd/wr pointers. `hist_data` is a combinational read of the head entry.
- Pop: `hist_rd`=1 and not empty advances the read pointer and decrements the count. `hist_rd` when empty is ignored and has no side effects.
- Push when full (no pop that cycle): the oldest entry is overwritten. The read pointer advances, the count stays at DEPTH, and `hist_ovf` is set.
- Push and pop in the same cycle:
  - Count is unchanged.
  - No overflow, even when full.
  - If empty, only the push takes effect.
- `hist_ovf` clears only on `Reset`.
- `B_fb` follows `Result` with no extra register.

## Timing
- Reset values: `Result`=0, `B_fb`=0, FSM=IDLE, pointers=0, `hist_count`=0, `hist_empty`=1, `hist_full`=0, `hist_ovf`=0, `hist_data`=0.
- Capture latency: `ALUout` is sampled at the edge where FSM=IDLE and `Capture`=1. `Result` and `hist_count` show the new value in the following cycle.
- Accumulate loop: the ALU recomputes from the new `B_fb` combinationally. The next capture needs a new press, so the loop never runs away.
- Pop: `hist_data` shows the next entry the cycle after the edge with `hist_rd`=1.
- `Reset` has priority over everything. Asserting it mid-press returns the FSM to IDLE. If `Capture` is still high the cycle after `Reset` drops, that counts as a new press and captures.

## Configuration
- `ALU_HIST_EN` defined: the history FIFO is built as described above.
- `ALU_HIST_EN` undefined: no FIFO storage is instantiated. `hist_data`=0, `hist_count`=0, `hist_empty`=1, `hist_full`=0, `hist_ovf`=0 constantly, and `hist_rd` is ignored. Capture FSM, `Result` and `B_fb` are unchanged.

## Test plan
- Reset, then hold `Capture`=1 for 5 cycles with `ALUout`=8'h3C, `Function`=2'b00 -> one capture only. `Result`=8'h3C, `B_fb`=4'hC, `hist_count`=1, `hist_data`=10'h03C.
- `ALUout` changes to 8'h55 while `Capture` is still held -> `Result` stays 8'h3C. Release, then press -> `Result`=8'h55, `hist_count`=2.
- DEPTH=4: five captures of 8'h01..8'h05 -> `hist_full`=1, `hist_ovf`=1, `hist_count`=4. Popping returns 8'h02, 8'h03, 8'h04, 8'h05, then `hist_empty`=1.
- FIFO full, capture 8'hAA in the same cycle as `hist_rd`=1 -> count stays 4, `hist_ovf` stays 0, head advances by one. A further `hist_rd` on an empty FIFO changes nothing.
- `Reset` pulse while FSM is in HOLD with `Capture` high -> all outputs return to reset values. A capture occurs the cycle after `Reset` deasserts.
- Build without `ALU_HIST_EN` -> capture behaviour is identical to the first scenario, `hist_empty`=1 and `hist_count`=0 throughout.
